udp_cmos_rev: RTL

Receive-side counterpart of the camera-to-Ethernet UDP sender. Parses GMII receive frames (preamble, Ethernet, IPv4, UDP) and filters on local MAC, IP and port. Strips the one-byte line-flag header and streams the image-line pixel bytes out with line/frame markers, for a downstream line buffer or display path. Single clock domain: the GMII RX clock.

---
 rtl/udp_cmos_rev.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/udp_cmos_rev.sv
// rtl/udp_cmos_rev.sv - GMII UDP image-line receiver with MAC/IP/port filter; define UDP_RX_CRC_EN to check the FCS
module udp_cmos_rev #(
    parameter logic [47:0] LOCAL_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] LOCAL_IP   = 32'hC0_A8_01_0A,
    parameter logic [15:0] LOCAL_PORT = 16'd1234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    output logic        line_first,
    output logic        line_last,
    output logic        line_done,
    output logic        line_ok,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] rx_pkt_cnt
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL, DROP
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] pay_len;
    logic [7:0]  len_hi;
    logic [2:0]  pre_cnt;
    logic [1:0]  flag;
    logic        mac_loc, mac_bc;
    logic [47:0] sh_mac;
    logic [31:0] sh_ip;
    logic        armed;
    logic [7:0]  mac_byte, ip_byte;
    logic        mac_loc_n, mac_bc_n;
    logic        crc_ok;

    always_comb begin
        mac_byte = 8'h00;
        case (cnt[2:0])
            3'd0: mac_byte = LOCAL_MAC[47:40];
            3'd1: mac_byte = LOCAL_MAC[39:32];
            3'd2: mac_byte = LOCAL_MAC[31:24];
            3'd3: mac_byte = LOCAL_MAC[23:16];
            3'd4: mac_byte = LOCAL_MAC[15:8];
            3'd5: mac_byte = LOCAL_MAC[7:0];
            default: mac_byte = 8'h00;
        endcase
        ip_byte = 8'h00;
        case (cnt[1:0])
            2'd0: ip_byte = LOCAL_IP[31:24];
            2'd1: ip_byte = LOCAL_IP[23:16];
            2'd2: ip_byte = LOCAL_IP[15:8];
            default: ip_byte = LOCAL_IP[7:0];
        endcase
        mac_loc_n = mac_loc && (gmii_rxd == mac_byte);
        mac_bc_n  = mac_bc && (gmii_rxd == 8'hFF);
    end

`ifdef UDP_RX_CRC_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || state == PREAMBLE)
            crc <= 32'hFFFF_FFFF;
        else if (gmii_rx_dv && state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL})
            crc <= crc_next(crc, gmii_rxd);
    end

    // The LSB-first register holds the bit-reversed form of residue 0xC704DD7B
    assign crc_ok = (crc == 32'hDEBB20E3);
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pay_len    <= '0;
            len_hi     <= '0;
            pre_cnt    <= '0;
            flag       <= '0;
            mac_loc    <= 1'b0;
            mac_bc     <= 1'b0;
            sh_mac     <= '0;
            sh_ip      <= '0;
            armed      <= 1'b0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            line_first <= 1'b0;
            line_last  <= 1'b0;
            line_done  <= 1'b0;
            line_ok    <= 1'b0;
            src_mac    <= '0;
            src_ip     <= '0;
            rx_pkt_cnt <= '0;
        end else begin
            pix_valid  <= 1'b0;
            line_first <= 1'b0;
            line_last  <= 1'b0;
            line_done  <= 1'b0;
            line_ok    <= 1'b0;
            cnt        <= cnt + 16'd1;
            if (!gmii_rx_dv)
                armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (gmii_rx_dv) begin
                        if (armed && gmii_rxd == 8'h55) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!gmii_rx_dv)
                        state <= IDLE;
                    else if (gmii_rxd == 8'h55) begin
                        if (pre_cnt != 3'd7)
                            pre_cnt <= pre_cnt + 3'd1;
                    end else if (gmii_rxd == 8'hD5 && pre_cnt >= 3'd6) begin
                        state   <= ETH_HDR;
                        cnt     <= '0;
                        mac_loc <= 1'b1;
                        mac_bc  <= 1'b1;
                    end else
                        state <= DROP;
                end
                ETH_HDR: begin
                    if (!gmii_rx_dv)
                        state <= IDLE;
                    else if (cnt <= 16'd5) begin
                        mac_loc <= mac_loc_n;
                        mac_bc  <= mac_bc_n;
                        if (cnt == 16'd5 && !(mac_loc_n || mac_bc_n))
                            state <= DROP;
                    end else if (cnt <= 16'd11)
                        sh_mac <= {sh_mac[39:0], gmii_rxd};
                    else if (cnt == 16'd12) begin
                        if (gmii_rxd != 8'h08)
                            state <= DROP;
                    end else if (gmii_rxd != 8'h00)
                        state <= DROP;
                    else begin
                        state <= IP_HDR;
                        cnt   <= '0;
                    end
                end
                IP_HDR: begin
                    if (!gmii_rx_dv)
                        state <= IDLE;
                    else if ((cnt == 16'd0 && gmii_rxd != 8'h45) || (cnt == 16'd9 && gmii_rxd != 8'h11))
                        state <= DROP;
                    else if (cnt >= 16'd12 && cnt <= 16'd15)
                        sh_ip <= {sh_ip[23:0], gmii_rxd};
                    else if (cnt >= 16'd16) begin
                        if (gmii_rxd != ip_byte)
                            state <= DROP;
                        else if (cnt == 16'd19) begin
                            state <= UDP_HDR;
                            cnt   <= '0;
                        end
                    end
                end
                UDP_HDR: begin
                    if (!gmii_rx_dv)
                        state <= IDLE;
                    else if ((cnt == 16'd2 && gmii_rxd != LOCAL_PORT[15:8]) ||
                             (cnt == 16'd3 && gmii_rxd != LOCAL_PORT[7:0]))
                        state <= DROP;
                    else if (cnt == 16'd4)
                        len_hi <= gmii_rxd;
                    else if (cnt == 16'd5) begin
                        if ({len_hi, gmii_rxd} < 16'd9)
                            state <= DROP;
                        pay_len <= {len_hi, gmii_rxd} - 16'd8;
                    end else if (cnt == 16'd7) begin
                        state <= PAYLOAD;
                        cnt   <= '0;
                    end
                end
                PAYLOAD: begin
                    if (!gmii_rx_dv) begin
                        state     <= IDLE;
                        line_done <= 1'b1;
                    end else begin
                        if (cnt == 16'd0)
                            flag <= gmii_rxd[1:0];
                        else begin
                            pix_valid  <= 1'b1;
                            pix_data   <= gmii_rxd;
                            line_first <= (cnt == 16'd1) && flag[0];
                            line_last  <= (cnt == 16'd1) && flag[1];
                        end
                        if (cnt == pay_len - 16'd1)
                            state <= TAIL;
                    end
                end
                TAIL: begin
                    if (!gmii_rx_dv) begin
                        state     <= IDLE;
                        line_done <= 1'b1;
                        line_ok   <= crc_ok;
                        src_mac   <= sh_mac;
                        src_ip    <= sh_ip;
                        if (crc_ok)
                            rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
                    end
                end
                default: begin
                    if (!gmii_rx_dv)
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule
